// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronizes, debounces and edge-detects raw pushbuttons per channel,
// producing a clean level, press/release pulses and a long-press flag.
module btn_conditioner #(
    parameter int NUM_BTN    = 3,
    parameter int DB_COUNT   = 500000,
    parameter int CNT_W      = 19,
    parameter int HOLD_COUNT = 50000000,
    parameter int HOLD_W     = 26
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_held
);
    logic [NUM_BTN-1:0] s1, s2;

    always_ff @(posedge clk or negedge clr)
        if (!clr) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [CNT_W-1:0]  cnt;
        logic [HOLD_W-1:0] hcnt;
        logic              lvl, prs, rel, hld, accept;

        assign accept = (s2[i] != lvl) && (cnt == CNT_W'(DB_COUNT - 1));

        always_ff @(posedge clk or negedge clr)
            if (!clr) begin
                cnt  <= '0;
                hcnt <= '0;
                lvl  <= 1'b0;
                prs  <= 1'b0;
                rel  <= 1'b0;
                hld  <= 1'b0;
            end else begin
                cnt <= (s2[i] == lvl || accept) ? '0 : cnt + 1'b1;
                lvl <= accept ? s2[i] : lvl;
                prs <= accept && s2[i];
                rel <= accept && !s2[i];
                // an accepted release drops held on the same edge as the release pulse
                if (!lvl || accept) begin
                    hcnt <= '0;
                    hld  <= 1'b0;
                end else if (!hld) begin
                    if (hcnt == HOLD_W'(HOLD_COUNT - 1))
                        hld <= 1'b1;
                    else
                        hcnt <= hcnt + 1'b1;
                end
            end

        assign btn_level[i]   = lvl;
        assign btn_press[i]   = prs;
        assign btn_release[i] = rel;
        assign btn_held[i]    = hld;
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed checks of debounce, pulses, hold flag and async reset.
module tb_btn_conditioner;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_held;
    logic [N-1:0] seen;
    int           tests = 0;
    int           fails = 0;

    btn_conditioner #(
        .NUM_BTN(N), .DB_COUNT(4), .CNT_W(3), .HOLD_COUNT(10), .HOLD_W(4)
    ) dut (
        .clk(clk), .clr(clr), .btn_raw(btn_raw), .btn_level(btn_level),
        .btn_press(btn_press), .btn_release(btn_release), .btn_held(btn_held)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #12;
        chk("rst_level", btn_level, 3'b000);
        chk("rst_press", btn_press, 3'b000);
        chk("rst_held", btn_held, 3'b000);
        @(posedge clk);
        #1 clr = 1'b1;
        step(2);

        // clean press on channel 0
        btn_raw = 3'b001;
        step(5);
        chk("press_e5_level", btn_level, 3'b000);
        chk("press_e5_press", btn_press, 3'b000);
        step(1);
        chk("press_e6_level", btn_level, 3'b001);
        chk("press_e6_press", btn_press, 3'b001);
        chk("press_e6_release", btn_release, 3'b000);
        step(1);
        chk("press_e7_press", btn_press, 3'b000);
        chk("press_e7_level", btn_level, 3'b001);

        // long press: held 10 cycles after level
        step(8);
        chk("held_e15", btn_held, 3'b000);
        step(1);
        chk("held_e16", btn_held, 3'b001);
        step(4);
        btn_raw = 3'b000;
        step(5);
        chk("rel_e5_level", btn_level, 3'b001);
        chk("rel_e5_held", btn_held, 3'b001);
        step(1);
        chk("rel_e6_level", btn_level, 3'b000);
        chk("rel_e6_held", btn_held, 3'b000);
        chk("rel_e6_release", btn_release, 3'b001);
        step(1);
        chk("rel_e7_release", btn_release, 3'b000);

        // bounce on channel 1
        seen = '0;
        for (int k = 0; k < 4; k++) begin
            btn_raw = (k % 2 == 0) ? 3'b010 : 3'b000;
            step(1);
            seen |= btn_level | btn_press;
        end
        btn_raw = 3'b010;
        for (int k = 0; k < 5; k++) begin
            step(1);
            seen |= btn_level | btn_press;
        end
        chk("bounce_quiet", seen, 3'b000);
        step(1);
        chk("bounce_press", btn_press, 3'b010);
        chk("bounce_level", btn_level, 3'b010);
        step(1);
        chk("bounce_press_once", btn_press, 3'b000);
        btn_raw = 3'b000;
        step(6);
        chk("bounce_release", btn_release, 3'b010);
        step(1);

        // short glitch on channel 2
        btn_raw = 3'b100;
        seen = '0;
        step(3);
        seen |= btn_level | btn_press | btn_release;
        btn_raw = 3'b000;
        for (int k = 0; k < 10; k++) begin
            step(1);
            seen |= btn_level | btn_press | btn_release;
        end
        chk("glitch_quiet", seen, 3'b000);

        // simultaneous press on all channels
        btn_raw = 3'b111;
        step(6);
        chk("sim_press", btn_press, 3'b111);
        step(1);
        chk("sim_press_clear", btn_press, 3'b000);
        chk("sim_level", btn_level, 3'b111);
        step(9);
        chk("sim_held", btn_held, 3'b111);

        // async reset with channel 1 mid-way through a release
        btn_raw = 3'b101;
        step(3);
        #2 clr = 1'b0;
        #1;
        chk("arst_level", btn_level, 3'b000);
        chk("arst_held", btn_held, 3'b000);
        chk("arst_press", btn_press, 3'b000);
        chk("arst_release", btn_release, 3'b000);
        @(posedge clk);
        #1 clr = 1'b1;
        step(5);
        chk("post_rst_e5_level", btn_level, 3'b000);
        step(1);
        chk("post_rst_press", btn_press, 3'b101);
        chk("post_rst_level", btn_level, 3'b101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
